// File: rtl/dcm_seq_pkg.sv
// Shared constants for the DCM reset sequencer: state encoding, parameter
// defaults and the counter sizing helper.
package dcm_seq_pkg;

  localparam int DEF_RST_PULSE_CYCLES    = 8;
  localparam int DEF_LOCK_TIMEOUT_CYCLES = 65536;
  localparam int DEF_SETTLE_CYCLES       = 1024;
  localparam int DEF_MAX_RETRIES         = 3;

  localparam int STATE_W = 3;
  localparam logic [STATE_W-1:0] ST_RST_DCM   = 3'd0;
  localparam logic [STATE_W-1:0] ST_WAIT_LOCK = 3'd1;
  localparam logic [STATE_W-1:0] ST_SETTLE    = 3'd2;
  localparam logic [STATE_W-1:0] ST_RUN       = 3'd3;
  localparam logic [STATE_W-1:0] ST_FLT       = 3'd4;

  typedef logic [1:0] retry_cnt_t;

  // One shared counter must hold the largest of the three cycle parameters.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/dcm_reset_sequencer_if.sv
// Control/status bundle between the DCM reset sequencer and its environment.
interface dcm_reset_sequencer_if;
  import dcm_seq_pkg::*;

  logic       DCM_LOCKED;
  logic       RESTART;
  logic       DCM_RESET;
  logic       SYS_RESET_N;
  logic       READY;
  logic       FAULT;
  retry_cnt_t RETRY_CNT;

  modport master (
    output DCM_LOCKED, RESTART,
    input  DCM_RESET, SYS_RESET_N, READY, FAULT, RETRY_CNT
  );

  modport slave (
    input  DCM_LOCKED, RESTART,
    output DCM_RESET, SYS_RESET_N, READY, FAULT, RETRY_CNT
  );

endinterface

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level input.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

// File: rtl/dcm_reset_sequencer.sv
// Sequences DCM reset, lock wait and settle before releasing the DCM-clocked
// domain reset; retries on lock failure and latches FAULT after the last try.
//
// state      | meaning
// RST_DCM    | DCM held in reset for RST_PULSE_CYCLES
// WAIT_LOCK  | DCM released, waiting for synchronized lock
// SETTLE     | lock seen, must hold SETTLE_CYCLES before release
// RUN        | system reset released, READY high
// FLT        | retries exhausted, DCM held in reset until RESTART
module dcm_reset_sequencer
  import dcm_seq_pkg::*;
#(
  parameter int RST_PULSE_CYCLES    = DEF_RST_PULSE_CYCLES,
  parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
  parameter int SETTLE_CYCLES       = DEF_SETTLE_CYCLES,
  parameter int MAX_RETRIES         = DEF_MAX_RETRIES
) (
  input  logic       CLK_IN,
  input  logic       RESET_N,
  input  logic       DCM_LOCKED,
  input  logic       RESTART,
  output logic       DCM_RESET,
  output logic       SYS_RESET_N,
  output logic       READY,
  output logic       FAULT,
  output retry_cnt_t RETRY_CNT
);

  localparam int CW = cnt_width(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES, SETTLE_CYCLES);
  localparam logic [CW-1:0] C_RST_LAST    = CW'(RST_PULSE_CYCLES - 1);
  localparam logic [CW-1:0] C_LOCK_LAST   = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] C_SETTLE_DONE = CW'(SETTLE_CYCLES);
  localparam logic [CW-1:0] C_SAT         = '1;
  localparam retry_cnt_t    C_MAX_RETRY   = retry_cnt_t'(MAX_RETRIES);

  logic               w_lock_s;
  logic               w_fail;
  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] w_state_nxt;
  logic [CW-1:0]      r_cnt;
  retry_cnt_t         r_retry;
  retry_cnt_t         w_retry_nxt;
  logic               r_dcm_reset;
  logic               r_sys_reset_n;
  logic               r_ready;
  logic               r_fault;

  sync2 u_lock_sync (
    .clk   (CLK_IN),
    .rst_n (RESET_N),
    .d     (DCM_LOCKED),
    .q     (w_lock_s)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_retry_nxt = r_retry;
    w_fail      = 1'b0;
    if (RESTART) begin
      w_state_nxt = ST_RST_DCM;
      w_retry_nxt = '0;
    end else begin
      case (r_state)
        ST_RST_DCM: begin
          if (r_cnt == C_RST_LAST) w_state_nxt = ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK: begin
          if (w_lock_s)                 w_state_nxt = ST_SETTLE;
          else if (r_cnt == C_LOCK_LAST) w_fail     = 1'b1;
        end
        // Exit at count SETTLE_CYCLES gives SETTLE_CYCLES+3 edges from the
        // first sampled lock to release, including the two synchronizer stages.
        ST_SETTLE: begin
          if (!w_lock_s)                   w_fail      = 1'b1;
          else if (r_cnt == C_SETTLE_DONE) w_state_nxt = ST_RUN;
        end
        ST_RUN: begin
          if (!w_lock_s) w_state_nxt = ST_RST_DCM;
        end
        ST_FLT:  w_state_nxt = ST_FLT;
        default: w_state_nxt = ST_RST_DCM;
      endcase

      if (w_fail) begin
        if (r_retry < C_MAX_RETRY) begin
          w_state_nxt = ST_RST_DCM;
          w_retry_nxt = r_retry + 2'd1;
        end else begin
          w_state_nxt = ST_FLT;
        end
      end

      if (w_state_nxt == ST_RUN) w_retry_nxt = '0;
    end
  end

  // Outputs are registered from the next state so they change on the same
  // edge as the state register.
  always_ff @(posedge CLK_IN or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state       <= ST_RST_DCM;
      r_cnt         <= '0;
      r_retry       <= '0;
      r_dcm_reset   <= 1'b1;
      r_sys_reset_n <= 1'b0;
      r_ready       <= 1'b0;
      r_fault       <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_retry <= w_retry_nxt;
      if (RESTART || (w_state_nxt != r_state)) r_cnt <= '0;
      else if (r_cnt != C_SAT)                 r_cnt <= r_cnt + 1'b1;
      r_dcm_reset   <= (w_state_nxt == ST_RST_DCM) || (w_state_nxt == ST_FLT);
      r_sys_reset_n <= (w_state_nxt == ST_RUN);
      r_ready       <= (w_state_nxt == ST_RUN);
      r_fault       <= (w_state_nxt == ST_FLT);
    end
  end

  assign DCM_RESET   = r_dcm_reset;
  assign SYS_RESET_N = r_sys_reset_n;
  assign READY       = r_ready;
  assign FAULT       = r_fault;
  assign RETRY_CNT   = r_retry;

endmodule

// File: tb/tb_dcm_reset_sequencer.sv
// Randomized scoreboard bench: stimulus computes expected output-change events
// from the sequencing rules; a monitor matches every observed change to them.
module tb_dcm_reset_sequencer;

  localparam int RP = 4;
  localparam int LT = 32;
  localparam int ST = 16;
  localparam int MR = 2;

  localparam logic [5:0] V_RUN = 6'b011000;

  typedef struct {
    int         edge_no;
    logic [5:0] val;
  } ev_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  dcm_reset_sequencer_if u_if ();

  always #5 clk = ~clk;

  dcm_reset_sequencer #(
    .RST_PULSE_CYCLES    (RP),
    .LOCK_TIMEOUT_CYCLES (LT),
    .SETTLE_CYCLES       (ST),
    .MAX_RETRIES         (MR)
  ) u_dut (
    .CLK_IN      (clk),
    .RESET_N     (rst_n),
    .DCM_LOCKED  (u_if.DCM_LOCKED),
    .RESTART     (u_if.RESTART),
    .DCM_RESET   (u_if.DCM_RESET),
    .SYS_RESET_N (u_if.SYS_RESET_N),
    .READY       (u_if.READY),
    .FAULT       (u_if.FAULT),
    .RETRY_CNT   (u_if.RETRY_CNT)
  );

  ev_t        exp_q[$];
  int         edge_n = 0;
  int         vectors = 0;
  int         miscompares = 0;
  logic [5:0] m_last;
  logic [5:0] mon_prev;
  logic [5:0] mon_cur;
  ev_t        mon_ev;
  int         m_t;
  int         m_rc;

  always @(posedge clk) edge_n <= edge_n + 1;

  // Output tuple: {DCM_RESET, SYS_RESET_N, READY, FAULT, RETRY_CNT}
  function automatic logic [5:0] v_rst(input int rc);
    return {4'b1000, 2'(rc)};
  endfunction
  function automatic logic [5:0] v_wait(input int rc);
    return {4'b0000, 2'(rc)};
  endfunction
  function automatic logic [5:0] v_flt(input int rc);
    return {4'b1001, 2'(rc)};
  endfunction
  function automatic logic [5:0] outs();
    return {u_if.DCM_RESET, u_if.SYS_RESET_N, u_if.READY, u_if.FAULT, u_if.RETRY_CNT};
  endfunction

  task automatic push(input int e, input logic [5:0] v);
    if (v != m_last) begin
      exp_q.push_back('{edge_no: e, val: v});
      m_last = v;
    end
  endtask

  task automatic check(input string name, input logic [5:0] got, input logic [5:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s got=%b want=%b", name, got, want);
    end
  endtask

  task automatic goto_edge(input int n);
    if (edge_n > n) begin
      miscompares++;
      $display("FAIL schedule now_edge=%0d target_edge=%0d", edge_n, n);
    end
    while (edge_n < n) @(negedge clk);
  endtask

  // m_t: edge at which the current phase began.
  task automatic mdl_fall();
    m_t = m_t + RP;
    push(m_t, v_wait(m_rc));
  endtask

  task automatic mdl_timeout();
    m_t = m_t + LT;
    if (m_rc < MR) begin
      m_rc++;
      push(m_t, v_rst(m_rc));
    end else begin
      push(m_t, v_flt(m_rc));
    end
  endtask

  // d: edge offset from WAIT_LOCK entry at which DCM_LOCKED is first sampled
  // high; -1 means it is already high on entry.
  task automatic mdl_lock(input int d);
    int l_edge;
    int run_edge;
    l_edge   = m_t + d;
    run_edge = l_edge + ST + 3;
    m_rc     = 0;
    push(run_edge, V_RUN);
    if (d > 0) begin
      goto_edge(l_edge - 1);
      u_if.DCM_LOCKED = 1'b1;
    end
    goto_edge(run_edge);
    m_t = run_edge;
  endtask

  task automatic lose_lock(input int g, input bit hold);
    m_t  = edge_n + 3;
    m_rc = 0;
    push(m_t, v_rst(0));
    u_if.DCM_LOCKED = 1'b0;
    if (!hold) begin
      repeat (g) @(negedge clk);
      u_if.DCM_LOCKED = 1'b1;
    end
  endtask

  task automatic do_restart();
    m_t  = edge_n + 1;
    m_rc = 0;
    push(m_t, v_rst(0));
    u_if.RESTART = 1'b1;
    @(negedge clk);
    u_if.RESTART = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog edge=%0d pending=%0d", edge_n, exp_q.size());
    $fatal(1, "watchdog expired");
  end

  initial begin
    u_if.DCM_LOCKED = 1'b0;
    u_if.RESTART    = 1'b0;
    m_last          = v_rst(0);
    mon_prev        = v_rst(0);
    m_rc            = 0;
    m_t             = 0;
    fork
      forever begin
        @(negedge clk);
        mon_cur = outs();
        if (mon_cur !== mon_prev) begin
          vectors++;
          if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_change edge=%0d got=%b", edge_n, mon_cur);
          end else begin
            mon_ev = exp_q.pop_front();
            if (mon_ev.edge_no != edge_n || mon_ev.val !== mon_cur) begin
              miscompares++;
              $display("FAIL output_event got edge=%0d val=%b want edge=%0d val=%b",
                       edge_n, mon_cur, mon_ev.edge_no, mon_ev.val);
            end
          end
          mon_prev = mon_cur;
        end
      end
      begin
        repeat (3) @(negedge clk);
        check("reset_state", outs(), v_rst(0));

        // Nominal bring-up: lock sampled 10 cycles after DCM_RESET falls.
        rst_n = 1'b1;
        m_t   = edge_n;
        mdl_fall();
        mdl_lock(10);

        // Short lock losses while running.
        for (int i = 0; i < 3; i++) begin
          int g;
          g = (i == 0) ? 1 : int'($urandom_range(RP, 1));
          goto_edge(edge_n + int'($urandom_range(12, 2)));
          lose_lock(g, 1'b0);
          mdl_fall();
          mdl_lock(-1);
        end

        // Lock dropped during SETTLE, then the remaining attempts time out.
        for (int i = 0; i < 2; i++) begin
          int d;
          int k;
          int l_edge;
          d = (i == 0) ? 10 : int'($urandom_range(LT - 2, 1));
          k = (i == 0) ? 8  : int'($urandom_range(ST - 2, 0));
          goto_edge(edge_n + 3);
          lose_lock(0, 1'b1);
          mdl_fall();
          l_edge = m_t + d;
          m_t    = l_edge + 5 + k;
          m_rc   = m_rc + 1;
          push(m_t, v_rst(m_rc));
          goto_edge(l_edge - 1);
          u_if.DCM_LOCKED = 1'b1;
          goto_edge(l_edge + 2 + k);
          u_if.DCM_LOCKED = 1'b0;
          mdl_fall();
          mdl_timeout();
          mdl_fall();
          mdl_timeout();
          goto_edge(m_t + int'($urandom_range(10, 1)));
          do_restart();
          mdl_fall();
          mdl_lock(int'($urandom_range(LT - 2, 1)));
        end

        // Three full timeouts into FLT, then RESTART with random retries.
        for (int i = 0; i < 2; i++) begin
          int n;
          goto_edge(edge_n + 2);
          lose_lock(0, 1'b1);
          for (int j = 0; j <= MR; j++) begin
            mdl_fall();
            mdl_timeout();
          end
          goto_edge(m_t + int'($urandom_range(20, 2)));
          do_restart();
          n = (i == 0) ? 0 : int'($urandom_range(MR, 1));
          for (int j = 0; j < n; j++) begin
            mdl_fall();
            mdl_timeout();
          end
          mdl_fall();
          mdl_lock(int'($urandom_range(LT - 2, 1)));
        end

        // RESTART on the timeout edge wins and clears RETRY_CNT; a second
        // RESTART inside the DCM pulse restarts the pulse.
        goto_edge(edge_n + 2);
        lose_lock(0, 1'b1);
        mdl_fall();
        mdl_timeout();
        mdl_fall();
        goto_edge(m_t + LT - 1);
        do_restart();
        goto_edge(m_t + 1);
        u_if.RESTART = 1'b1;
        @(negedge clk);
        u_if.RESTART = 1'b0;
        m_t = m_t + 2;
        mdl_fall();
        mdl_lock(int'($urandom_range(LT - 2, 1)));

        // Asynchronous reset pulse between edges during WAIT_LOCK.
        goto_edge(edge_n + 2);
        lose_lock(0, 1'b1);
        mdl_fall();
        mdl_timeout();
        mdl_fall();
        goto_edge(m_t + int'($urandom_range(LT - 3, 2)));
        push(edge_n + 1, v_rst(0));
        #2 rst_n = 1'b0;
        #1 check("async_reset", outs(), v_rst(0));
        #1 rst_n = 1'b1;
        m_t  = edge_n;
        m_rc = 0;
        mdl_fall();
        mdl_lock(int'($urandom_range(LT - 2, 1)));

        goto_edge(edge_n + 10);
        vectors++;
        if (exp_q.size() != 0) begin
          miscompares++;
          $display("FAIL pending_events got=%0d want=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
      end
    join_any
  end

endmodule

// File: doc/dcm_reset_sequencer.md
DCM_RESET_SEQUENCER -- requirements
Module: dcm_reset_sequencer

Interface
REQ-001 SHALL have parameter RST_PULSE_CYCLES, default 8: cycles DCM_RESET is held high per attempt (min 3).
REQ-002 SHALL have parameter LOCK_TIMEOUT_CYCLES, default 65536: cycles allowed for lock per attempt.
REQ-003 SHALL have parameter SETTLE_CYCLES, default 1024: cycles lock must hold before system reset release.
REQ-004 SHALL have parameter MAX_RETRIES, default 3: failed attempts before FAULT; the width of RETRY_CNT is 2 bits, so MAX_RETRIES SHALL be at most 3.
REQ-005 SHALL have port CLK_IN  input  1  free-running reference clock (pre-DCM); the block's only clock.
REQ-006 SHALL have port RESET_N  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port DCM_LOCKED  input  1  DCM LOCKED status, asynchronous to CLK_IN.
REQ-008 SHALL have port RESTART  input  1  synchronous single-cycle request to re-sequence.
REQ-009 SHALL have port DCM_RESET  output  1  active-high DCM RST drive.
REQ-010 SHALL have port SYS_RESET_N  output  1  active-low reset for the DCM-clocked domain.
REQ-011 SHALL have port READY  output  1  high only in RUN.
REQ-012 SHALL have port FAULT  output  1  sticky lock-failure flag.
REQ-013 SHALL have port RETRY_CNT  output  2  failed attempts in the current sequence.

Function
REQ-014 SHALL pass DCM_LOCKED through a 2-flop synchronizer; lock_s denotes the synchronized value, and all decisions SHALL use lock_s.
REQ-015 SHALL implement FSM states RST_DCM, WAIT_LOCK, SETTLE, RUN and FLT; all outputs SHALL be registered.
REQ-016 RST_DCM: DCM_RESET=1 and SYS_RESET_N=0; the FSM SHALL leave for WAIT_LOCK after exactly RST_PULSE_CYCLES cycles.
REQ-017 WAIT_LOCK: DCM_RESET=0 and the counter counts up; lock_s=1 SHALL go to SETTLE.
REQ-018 WAIT_LOCK: when the counter reaches LOCK_TIMEOUT_CYCLES with lock_s=0 and RETRY_CNT<MAX_RETRIES, the FSM SHALL increment RETRY_CNT and go to RST_DCM; otherwise it SHALL go to FLT.
REQ-019 SETTLE: after SETTLE_CYCLES consecutive cycles of lock_s=1, the FSM SHALL go to RUN; lock_s=0 SHALL be treated as a timeout per REQ-018.
REQ-020 RUN: SYS_RESET_N=1, READY=1 and RETRY_CNT cleared to 0; lock_s=0 SHALL deassert SYS_RESET_N and READY on the next edge and enter RST_DCM.
REQ-021 FLT: FAULT=1, DCM_RESET=1 and SYS_RESET_N=0; the state SHALL be held until RESTART or reset.
REQ-022 RESTART=1 in any state SHALL clear FAULT and RETRY_CNT and enter RST_DCM on the next edge; RESTART SHALL take priority over every other transition in the same cycle.
REQ-023 The single counter SHALL clear on every state entry and SHALL saturate, never wrap; its width SHALL be clog2 of the largest cycle parameter plus 1.
REQ-024 Latency: SYS_RESET_N SHALL rise exactly SETTLE_CYCLES+3 edges after the first edge sampling DCM_LOCKED=1 in WAIT_LOCK, provided DCM_LOCKED stays stable.
REQ-025 A DCM_LOCKED glitch shorter than 1 cycle that is missed by the synchronizer SHALL have no effect; one that is captured SHALL follow REQ-019 or REQ-020.

Reset
REQ-026 RESET_N low SHALL asynchronously force state RST_DCM, DCM_RESET=1, SYS_RESET_N=0, READY=0, FAULT=0, RETRY_CNT=0, counter=0 and the synchronizer flops to 0.
REQ-027 After RESET_N deasserts, the first RST_DCM pulse SHALL last the full RST_PULSE_CYCLES.

Structure
REQ-028 Package dcm_seq_pkg SHALL hold the state encoding constants and the parameter defaults.
REQ-029 The synchronizer SHALL be the sub-module sync2 (2 flops, async active-low reset); the FSM and counter SHALL stay in the top module.

Verification
(All scenarios use RST_PULSE_CYCLES=4, LOCK_TIMEOUT_CYCLES=32, SETTLE_CYCLES=16, MAX_RETRIES=2.)
REQ-030 Nominal: release RESET_N, then raise DCM_LOCKED 10 cycles after DCM_RESET falls -> DCM_RESET high for exactly 4 cycles; SYS_RESET_N and READY rise 19 edges after lock is sampled; RETRY_CNT=0.
REQ-031 Timeout/retry: hold DCM_LOCKED=0 -> three DCM_RESET pulses with RETRY_CNT 0->1->2; FLT after the third timeout; FAULT=1, DCM_RESET=1.
REQ-032 Lock loss in RUN: drop DCM_LOCKED for 1 cycle while in RUN -> SYS_RESET_N=0 three edges later, a fresh 4-cycle DCM_RESET pulse, and RETRY_CNT=0.
REQ-033 SETTLE interruption: drop lock at settle cycle 8 -> SYS_RESET_N never rises, RETRY_CNT=1, re-sequence begins.
REQ-034 RESTART from FLT, then assert lock -> FAULT clears next edge; nominal sequence follows to RUN.
REQ-035 Async reset mid-WAIT_LOCK: pulse RESET_N low between clock edges -> DCM_RESET=1 immediately without a clock edge; all outputs take their reset values.
